// File: rtl/or1200_dc_wb_burst.sv
// Wishbone B3 bus sequencer for the data cache.
// Turns biu_read/biu_write requests (single word or wrapped line burst)
// into classic or incrementing-wrap Wishbone cycles, with retry and abort.
module or1200_dc_wb_burst #(
    parameter int BEATS     = 4,
    parameter int RTY_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       biu_read,
    input  logic                       biu_write,
    input  logic                       burst,
    input  logic [31:0]                biu_addr,
    input  logic [3:0]                 biu_sel,
    input  logic [31:0]                biu_do,
    output logic [31:0]                biu_di,
    output logic                       biudata_valid,
    output logic                       biudata_error,
    output logic [$clog2(BEATS)-1:0]   biu_beat,
    output logic                       biu_busy,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [31:0]                wb_adr_o,
    output logic [3:0]                 wb_sel_o,
    output logic [31:0]                wb_dat_o,
    output logic [2:0]                 wb_cti_o,
    output logic [1:0]                 wb_bte_o,
    input  logic                       wb_ack_i,
    input  logic                       wb_err_i,
    input  logic                       wb_rty_i,
    input  logic [31:0]                wb_dat_i
);

    localparam int         L          = $clog2(BEATS);
    localparam logic [1:0] BTE_BURST  = (BEATS == 4) ? 2'b01 : (BEATS == 8) ? 2'b10 : 2'b11;
    localparam logic [2:0] CTI_SINGLE = 3'b000;
    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_END    = 3'b111;

    typedef enum logic [1:0] {IDLE, XFER, RETRY, WAITREL} state_t;

    state_t         state_q, state_d;
    logic [L-1:0]   cnt_q, cnt_d;      // beats remaining after the current one
    logic [L-1:0]   beat_q, beat_d;
    logic [29:0]    adr_q, adr_d;      // word address of the current beat
    logic           we_q, we_d;
    logic           burst_q, burst_d;
    logic [3:0]     sel_q, sel_d;      // effective byte lanes (4'hF for bursts)
    logic [3:0]     rty_q, rty_d;
    logic [2:0]     cti_q, cti_d;
    logic [1:0]     bte_q, bte_d;
    logic           cyc_q, cyc_d;

    logic req;
    logic xfer_live;
    logic beat_ack;

    assign req       = biu_read | biu_write;
    // A dropped request inside XFER is an abort: no termination is reported.
    assign xfer_live = (state_q == XFER) && req;
    assign beat_ack  = xfer_live && wb_ack_i && !wb_err_i && !wb_rty_i;

    // State and registered bus outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            sel_q   <= '0;
            rty_q   <= '0;
            cti_q   <= '0;
            bte_q   <= '0;
            cyc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            sel_q   <= sel_d;
            rty_q   <= rty_d;
            cti_q   <= cti_d;
            bte_q   <= bte_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next state plus beat counter / address / request-attribute updates.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        adr_d   = adr_q;
        we_d    = we_q;
        burst_d = burst_q;
        sel_d   = sel_q;
        rty_d   = rty_q;
        bte_d   = bte_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = XFER;
                    we_d    = !biu_read;           // read wins when both are set
                    burst_d = burst;
                    adr_d   = biu_addr[31:2];
                    sel_d   = burst ? 4'hF : biu_sel;
                    cnt_d   = burst ? L'(BEATS - 1) : '0;
                    beat_d  = '0;
                    bte_d   = burst ? BTE_BURST : 2'b00;
                end
            end
            XFER: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (wb_err_i) begin
                    state_d = WAITREL;
                end else if (wb_rty_i) begin
                    state_d = RETRY;
                    rty_d   = 4'(RTY_DELAY - 1);
                end else if (wb_ack_i) begin
                    if (cnt_q == '0) begin
                        state_d = WAITREL;
                    end else begin
                        cnt_d  = cnt_q - L'(1);
                        beat_d = beat_q + L'(1);
                        // Only the in-line word bits advance, so the burst wraps inside the line.
                        adr_d  = {adr_q[29:L], adr_q[L-1:0] + L'(1)};
                    end
                end
            end
            RETRY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (rty_q == '0) begin
                    state_d = XFER;
                end else begin
                    rty_d = rty_q - 4'd1;
                end
            end
            WAITREL: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of registered bus outputs and the combinational beat status.
    always_comb begin
        cyc_d         = (state_d == XFER);
        cti_d         = !burst_d ? CTI_SINGLE : (cnt_d == '0) ? CTI_END : CTI_INCR;
        biudata_valid = beat_ack;
        biudata_error = xfer_live && wb_err_i;
        biu_busy      = (state_q != IDLE);
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = {adr_q, 2'b00};
    assign wb_sel_o = sel_q;
    assign wb_cti_o = cti_q;
    assign wb_bte_o = bte_q;
    assign wb_dat_o = biu_do;
    assign biu_di   = wb_dat_i;
    assign biu_beat = beat_q;

endmodule

// File: tb/tb_or1200_dc_wb_burst.sv
// Self-checking bench for or1200_dc_wb_burst: a scripted Wishbone slave
// plus a line-address model derived from the wrap-burst rules.
module tb_or1200_dc_wb_burst;

    localparam int BEATS     = 4;
    localparam int RTY_DELAY = 2;
    localparam int L         = $clog2(BEATS);

    logic          clk;
    logic          rst;
    logic          biu_read, biu_write, burst;
    logic [31:0]   biu_addr;
    logic [3:0]    biu_sel;
    logic [31:0]   biu_do;
    logic [31:0]   biu_di;
    logic          biudata_valid, biudata_error;
    logic [L-1:0]  biu_beat;
    logic          biu_busy;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0]   wb_adr_o;
    logic [3:0]    wb_sel_o;
    logic [31:0]   wb_dat_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic          wb_ack_i, wb_err_i, wb_rty_i;
    logic [31:0]   wb_dat_i;

    or1200_dc_wb_burst #(.BEATS(BEATS), .RTY_DELAY(RTY_DELAY)) dut (
        .clk(clk), .rst(rst),
        .biu_read(biu_read), .biu_write(biu_write), .burst(burst),
        .biu_addr(biu_addr), .biu_sel(biu_sel), .biu_do(biu_do), .biu_di(biu_di),
        .biudata_valid(biudata_valid), .biudata_error(biudata_error),
        .biu_beat(biu_beat), .biu_busy(biu_busy),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_dat_i(wb_dat_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Slave script: 0 = wait, 1 = ack, 2 = err, 3 = rty; empty queue means ack.
    int           rsp_q[$];
    int           kill_at   = -1;   // bus-cycle index at which the requester interferes
    int           kill_kind = 0;    // 1 = drop request, 2 = assert reset
    int           n_valid, n_err, n_rec;
    logic         done_flag;
    logic [31:0]  wdata [16];

    // Wrapped line address of beat k, from plain line/word arithmetic.
    function automatic logic [31:0] exp_adr(input logic [31:0] a, input logic b, input int k);
        int unsigned au, line, word;
        au = a;
        if (!b) return {a[31:2], 2'b00};
        line = au - (au % (BEATS * 4));
        word = ((au >> 2) + k) % BEATS;
        return 32'(line + word * 4);
    endfunction

    function automatic logic [1:0] exp_bte();
        case (BEATS)
            4:       return 2'b01;
            8:       return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Runs one transaction against the scripted slave, comparing every bus cycle with the model.
    task automatic drive_txn(input logic rd, input logic wr, input logic bst,
                             input logic [31:0] addr, input logic [3:0] sel, input int stop_valid);
        int k, gap, exp_gap, rsp, budget;
        logic [31:0] rdat, e_adr;
        logic [2:0]  e_cti;
        logic [1:0]  e_bte;
        logic [3:0]  e_sel;
        logic        e_we, killed, e_valid, e_err;
        for (int i = 0; i < 16; i++) wdata[i] = $urandom;
        k = 0; gap = 0; exp_gap = 0; budget = 0;
        n_rec = 0; n_valid = 0; n_err = 0; done_flag = 1'b0;
        e_we  = !rd && wr;
        e_sel = bst ? 4'hF : sel;
        e_bte = bst ? exp_bte() : 2'b00;
        biu_read = rd; biu_write = wr; burst = bst;
        biu_addr = addr; biu_sel = sel; biu_do = wdata[0];
        while (!done_flag && budget < 300) begin
            @(negedge clk);
            budget++;
            biu_do = wdata[k % 16];
            if (wb_cyc_o) begin
                rsp  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 1;
                rdat = $urandom;
                wb_ack_i = (rsp == 1); wb_err_i = (rsp == 2); wb_rty_i = (rsp == 3);
                wb_dat_i = rdat;
                killed = (n_rec == kill_at);
                if (killed) begin
                    if (kill_kind == 1) begin biu_read = 1'b0; biu_write = 1'b0; end
                    else rst = 1'b0;
                end
                #1;
                e_adr   = exp_adr(addr, bst, k);
                e_cti   = !bst ? 3'b000 : (k == BEATS - 1) ? 3'b111 : 3'b010;
                e_valid = (rsp == 1) && !(killed && kill_kind == 1);
                e_err   = (rsp == 2) && !(killed && kill_kind == 1);
                checks++; if (gap !== exp_gap) $display("FAIL gap cyc%0d got %0d exp %0d", n_rec, gap, exp_gap); else passed++;
                checks++; if (wb_adr_o !== e_adr) $display("FAIL adr cyc%0d got %h exp %h", n_rec, wb_adr_o, e_adr); else passed++;
                checks++; if (wb_cti_o !== e_cti) $display("FAIL cti cyc%0d got %b exp %b", n_rec, wb_cti_o, e_cti); else passed++;
                checks++; if (wb_bte_o !== e_bte) $display("FAIL bte cyc%0d got %b exp %b", n_rec, wb_bte_o, e_bte); else passed++;
                checks++; if (wb_sel_o !== e_sel) $display("FAIL sel cyc%0d got %b exp %b", n_rec, wb_sel_o, e_sel); else passed++;
                checks++; if (wb_we_o !== e_we) $display("FAIL we cyc%0d got %b exp %b", n_rec, wb_we_o, e_we); else passed++;
                checks++; if (wb_stb_o !== 1'b1) $display("FAIL stb cyc%0d got %b exp 1", n_rec, wb_stb_o); else passed++;
                checks++; if (biu_beat !== L'(k)) $display("FAIL beat cyc%0d got %0d exp %0d", n_rec, biu_beat, k); else passed++;
                checks++; if (wb_dat_o !== wdata[k % 16]) $display("FAIL wdat cyc%0d got %h exp %h", n_rec, wb_dat_o, wdata[k % 16]); else passed++;
                checks++; if (biudata_valid !== e_valid) $display("FAIL valid cyc%0d got %b exp %b", n_rec, biudata_valid, e_valid); else passed++;
                checks++; if (biudata_error !== e_err) $display("FAIL error cyc%0d got %b exp %b", n_rec, biudata_error, e_err); else passed++;
                if (e_valid && rd) begin
                    checks++; if (biu_di !== rdat) $display("FAIL rdat cyc%0d got %h exp %h", n_rec, biu_di, rdat); else passed++;
                end
                n_rec++;
                if (killed) begin
                    done_flag = 1'b1;
                end else begin
                    if (rsp == 1) begin
                        n_valid++; k++;
                        if (n_valid == stop_valid) done_flag = 1'b1;
                    end
                    if (rsp == 2) begin n_err++; done_flag = 1'b1; end
                end
                exp_gap = (rsp == 3) ? RTY_DELAY : 0;
                gap = 0;
            end else begin
                // Acks while the bus is idle must never reach the requester.
                wb_ack_i = 1'($urandom_range(0, 1)); wb_err_i = 1'b0; wb_rty_i = 1'b0;
                #1;
                checks++; if (biudata_valid !== 1'b0 || biudata_error !== 1'b0)
                    $display("FAIL gated got v=%b e=%b exp 0", biudata_valid, biudata_error); else passed++;
                gap++;
            end
        end
        checks++; if (!done_flag) $display("FAIL txn_timeout got busy=%b exp done", biu_busy); else passed++;
        @(negedge clk);
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        biu_do = wdata[k % 16];
        checks++; if (wb_cyc_o !== 1'b0) $display("FAIL cyc_after got %b exp 0", wb_cyc_o); else passed++;
        kill_at = -1;
    endtask

    task automatic release_req();
        biu_read = 1'b0; biu_write = 1'b0;
        @(negedge clk);
        checks++; if (biu_busy !== 1'b0) $display("FAIL busy_release got %b exp 0", biu_busy); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0; biu_read = 1'b0; biu_write = 1'b0; burst = 1'b0;
        biu_addr = '0; biu_sel = '0; biu_do = '0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
        repeat (3) @(negedge clk);
        checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) $display("FAIL rst_ctl got %b exp 000", {wb_cyc_o, wb_stb_o, wb_we_o}); else passed++;
        checks++; if (wb_adr_o !== 32'h0) $display("FAIL rst_adr got %h exp 0", wb_adr_o); else passed++;
        checks++; if ({wb_sel_o, wb_cti_o, wb_bte_o} !== 9'h0) $display("FAIL rst_sel_cti_bte got %h exp 0", {wb_sel_o, wb_cti_o, wb_bte_o}); else passed++;
        checks++; if (biu_beat !== '0 || biu_busy !== 1'b0) $display("FAIL rst_beat_busy got %0d/%b exp 0/0", biu_beat, biu_busy); else passed++;
        rst = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b1;
        #1;
        checks++; if (biudata_valid !== 1'b0) $display("FAIL idle_ack got %b exp 0", biudata_valid); else passed++;
        wb_ack_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_burst();
        rsp_q = {1, 1, 1, 1};
        drive_txn(1'b1, 1'b0, 1'b1, 32'h0000_1008, 4'h0, BEATS);
        checks++; if (n_valid !== BEATS) $display("FAIL burst_beats got %0d exp %0d", n_valid, BEATS); else passed++;
        // A held request must not re-issue from WAITREL.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wb_cyc_o !== 1'b0 || biu_busy !== 1'b1) $display("FAIL waitrel got cyc=%b busy=%b exp 0/1", wb_cyc_o, biu_busy); else passed++;
        end
        release_req();
    endtask

    task automatic test_single_write();
        rsp_q = {0, 0, 1};
        drive_txn(1'b0, 1'b1, 1'b0, 32'h0000_2346, 4'b0011, 1);
        checks++; if (n_valid !== 1 || n_rec !== 3) $display("FAIL single_write got v=%0d c=%0d exp 1/3", n_valid, n_rec); else passed++;
        @(negedge clk);
        checks++; if (wb_cyc_o !== 1'b0 || biu_busy !== 1'b1) $display("FAIL write_hold got cyc=%b busy=%b exp 0/1", wb_cyc_o, biu_busy); else passed++;
        release_req();
    endtask

    task automatic test_error();
        rsp_q = {1, 1, 2};
        drive_txn(1'b1, 1'b0, 1'b1, 32'h0000_3004, 4'h0, BEATS);
        checks++; if (n_err !== 1 || n_valid !== 2) $display("FAIL err_burst got e=%0d v=%0d exp 1/2", n_err, n_valid); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (wb_cyc_o !== 1'b0) $display("FAIL err_no_beat3 got cyc=%b exp 0", wb_cyc_o); else passed++;
        end
        release_req();
    endtask

    task automatic test_retry();
        rsp_q = {1, 3, 1, 1, 1};
        drive_txn(1'b1, 1'b0, 1'b1, 32'h0000_400C, 4'h0, BEATS);
        checks++; if (n_valid !== BEATS || n_rec !== BEATS + 1) $display("FAIL retry_burst got v=%0d c=%0d exp %0d/%0d", n_valid, n_rec, BEATS, BEATS + 1); else passed++;
        release_req();
    endtask

    task automatic test_abort();
        rsp_q = {1, 0};
        kill_at = 1; kill_kind = 1;
        drive_txn(1'b1, 1'b0, 1'b1, 32'h0000_5000, 4'h0, BEATS);
        checks++; if (biu_busy !== 1'b0 || n_valid !== 1) $display("FAIL abort got busy=%b v=%0d exp 0/1", biu_busy, n_valid); else passed++;
        wb_ack_i = 1'b1;
        #1;
        checks++; if (biudata_valid !== 1'b0) $display("FAIL abort_valid got %b exp 0", biudata_valid); else passed++;
        wb_ack_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        rsp_q = {1, 1, 0};
        kill_at = 2; kill_kind = 2;
        drive_txn(1'b1, 1'b0, 1'b1, 32'h0000_6008, 4'h0, BEATS);
        checks++; if ({wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o} !== 11'h0 || wb_adr_o !== 32'h0)
            $display("FAIL rst_mid_out got adr=%h cti=%b exp 0", wb_adr_o, wb_cti_o); else passed++;
        checks++; if (biu_beat !== '0 || biu_busy !== 1'b0) $display("FAIL rst_mid_state got %0d/%b exp 0/0", biu_beat, biu_busy); else passed++;
        biu_read = 1'b0; rst = 1'b1;
        @(negedge clk);
        rsp_q = {1, 1, 1, 1};
        drive_txn(1'b1, 1'b0, 1'b1, 32'h0000_6008, 4'h0, BEATS);
        checks++; if (n_valid !== BEATS) $display("FAIL after_rst got %0d exp %0d", n_valid, BEATS); else passed++;
        release_req();
    endtask

    task automatic test_random();
        int r, mode;
        logic bst, rd, wr;
        for (int t = 0; t < 25; t++) begin
            rsp_q.delete();
            for (int j = 0; j < 12; j++) begin
                r = $urandom_range(0, 99);
                rsp_q.push_back(r < 30 ? 0 : r < 80 ? 1 : r < 94 ? 3 : 2);
            end
            mode = $urandom_range(0, 2);
            rd  = (mode != 1);
            wr  = (mode != 0);
            bst = 1'($urandom_range(0, 1));
            drive_txn(rd, wr, bst, $urandom, 4'($urandom), bst ? BEATS : 1);
            checks++; if (n_valid + n_err < 1) $display("FAIL rand_txn%0d got no termination", t); else passed++;
            release_req();
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_single_write();
        test_error();
        test_retry();
        test_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
